// File: rtl/elevator_ctrl.sv
// elevator_ctrl: SCAN-order N-floor elevator controller
// driving a unipolar stepper through an 8-phase sequencer.
module elevator_ctrl #(
  parameter int FLOORS          = 4,
  parameter int STEPS_PER_FLOOR = 5688,
  parameter int STEP_DIV        = 80000,
  parameter int DWELL           = 50000000,
  parameter int HALF_STEP       = 1
) (
  input  logic              clk,
  input  logic              reset_p,
  input  logic [FLOORS-1:0] call,
  output logic [3:0]        motorpin,
  output logic [FLOORS-1:0] floor_led,
  output logic [FLOORS-1:0] pending,
  output logic              moving,
  output logic              dir_up,
  output logic              door_open
);
  localparam int FW = $clog2(FLOORS);
  localparam int SW = $clog2(STEPS_PER_FLOOR + 1);
  localparam int TW = $clog2(STEP_DIV);
  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [2:0] PH0 = (HALF_STEP != 0) ? 3'd0 : 3'd1;
  localparam logic [2:0] INC = (HALF_STEP != 0) ? 3'd1 : 3'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MOVE,
    S_ARRIVE,
    S_DWELL
  } state_t;

  state_t        state;
  logic [FW-1:0] floor;
  logic [2:0]    phase;
  logic [TW-1:0] step_timer;
  logic [SW-1:0] step_cnt;
  logic [DW-1:0] dwell_cnt;

  logic [FLOORS-1:0] set_mask;
  logic [FW-1:0]     floor_nxt;
  logic [2:0]        phase_nxt;
  logic any_above, any_below, any_ahead, any_behind;
  logic open_here, here_hit, here_pend, tick, last_step;

  function automatic logic [3:0] decode(input logic [2:0] p);
    logic [3:0] m;
    unique case (p)
      3'd0: m = 4'b1000;
      3'd1: m = 4'b1100;
      3'd2: m = 4'b0100;
      3'd3: m = 4'b0110;
      3'd4: m = 4'b0010;
      3'd5: m = 4'b0011;
      3'd6: m = 4'b0001;
      3'd7: m = 4'b1001;
    endcase
    return m;
  endfunction

  always_comb begin
    any_above = 1'b0;
    any_below = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if (pending[i] && i > int'(floor)) any_above = 1'b1;
      if (pending[i] && i < int'(floor)) any_below = 1'b1;
    end
  end

  // floor_led is kept as the one-hot copy of floor
  assign any_ahead  = dir_up ? any_above : any_below;
  assign any_behind = dir_up ? any_below : any_above;
  assign open_here  = (state == S_IDLE) || (state == S_DWELL);
  assign here_hit   = open_here && |(call & floor_led);
  assign here_pend  = |(pending & floor_led);
  assign set_mask   = open_here ? (call & ~floor_led) : call;
  assign tick       = step_timer == TW'(STEP_DIV - 1);
  assign last_step  = step_cnt == SW'(STEPS_PER_FLOOR - 1);
  assign phase_nxt  = dir_up ? phase + INC : phase - INC;

  always_comb begin
    floor_nxt = floor;
    if (dir_up && floor != FW'(FLOORS - 1))
      floor_nxt = floor + 1'b1;
    if (!dir_up && floor != '0)
      floor_nxt = floor - 1'b1;
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state      <= S_IDLE;
      floor      <= '0;
      floor_led  <= FLOORS'(1);
      pending    <= '0;
      dir_up     <= 1'b1;
      door_open  <= 1'b0;
      moving     <= 1'b0;
      motorpin   <= 4'b0000;
      phase      <= PH0;
      step_timer <= '0;
      step_cnt   <= '0;
      dwell_cnt  <= '0;
    end else begin
      pending <= pending | set_mask;
      unique case (state)
        S_IDLE: begin
          if (here_hit || here_pend) begin
            pending   <= (pending | set_mask) & ~floor_led;
            state     <= S_DWELL;
            door_open <= 1'b1;
            dwell_cnt <= '0;
          end else if (|pending) begin
            if (!any_ahead) dir_up <= ~dir_up;
            state      <= S_MOVE;
            moving     <= 1'b1;
            motorpin   <= decode(phase);
            step_timer <= '0;
            step_cnt   <= '0;
          end
        end
        S_MOVE: begin
          step_timer <= tick ? '0 : step_timer + 1'b1;
          if (tick) begin
            phase    <= phase_nxt;
            motorpin <= decode(phase_nxt);
            if (last_step) begin
              step_cnt  <= '0;
              floor     <= floor_nxt;
              floor_led <= FLOORS'(1) << floor_nxt;
              state     <= S_ARRIVE;
            end else begin
              step_cnt <= step_cnt + 1'b1;
            end
          end
        end
        S_ARRIVE: begin
          step_timer <= '0;
          if (here_pend) begin
            pending   <= (pending | set_mask) & ~floor_led;
            state     <= S_DWELL;
            door_open <= 1'b1;
            dwell_cnt <= '0;
            moving    <= 1'b0;
            motorpin  <= 4'b0000;
          end else if (any_ahead) begin
            state <= S_MOVE;
          end else if (any_behind) begin
            dir_up <= ~dir_up;
            state  <= S_MOVE;
          end else begin
            state    <= S_IDLE;
            moving   <= 1'b0;
            motorpin <= 4'b0000;
          end
        end
        S_DWELL: begin
          if (here_hit) begin
            dwell_cnt <= '0;
          end else if (dwell_cnt == DW'(DWELL - 1)) begin
            state     <= S_IDLE;
            door_open <= 1'b0;
            dwell_cnt <= '0;
          end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_elevator_ctrl.sv
// Scoreboard bench for elevator_ctrl: half- and full-step
// instances against a position-based reference model.
module tb_elevator_ctrl;
  localparam int NF   = 4;
  localparam int SPF  = 4;
  localparam int SDIV = 3;
  localparam int DWL  = 10;

  localparam int M_IDLE = 0;
  localparam int M_MOVE = 1;
  localparam int M_ARR  = 2;
  localparam int M_DOOR = 3;

  typedef struct packed {
    logic [3:0]    mp;
    logic [NF-1:0] fl;
    logic [NF-1:0] pd;
    logic          mv;
    logic          du;
    logic          dr;
  } out_t;

  typedef struct packed {
    logic [31:0] cyc;
    out_t        o;
  } rec_t;

  logic clk = 1'b0;
  logic reset_p = 1'b1;
  logic [NF-1:0] call = '0;
  logic [3:0] mp [2];
  logic [NF-1:0] fl [2];
  logic [NF-1:0] pd [2];
  logic mv [2];
  logic du [2];
  logic dr [2];

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  logic [3:0] ptab [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                           4'b0010, 4'b0011, 4'b0001, 4'b1001};

  int m_mode [2];
  int m_pos [2];
  int m_el [2];
  int m_left [2];
  bit m_up [2];
  bit [NF-1:0] m_req [2];
  out_t m_last [2];
  out_t prev [2];
  rec_t q0 [$];
  rec_t q1 [$];

  always #5 clk = ~clk;

  elevator_ctrl #(
    .FLOORS(NF), .STEPS_PER_FLOOR(SPF), .STEP_DIV(SDIV),
    .DWELL(DWL), .HALF_STEP(1)
  ) u_half (
    .clk(clk), .reset_p(reset_p), .call(call),
    .motorpin(mp[0]), .floor_led(fl[0]), .pending(pd[0]),
    .moving(mv[0]), .dir_up(du[0]), .door_open(dr[0])
  );

  elevator_ctrl #(
    .FLOORS(NF), .STEPS_PER_FLOOR(SPF), .STEP_DIV(SDIV),
    .DWELL(DWL), .HALF_STEP(0)
  ) u_full (
    .clk(clk), .reset_p(reset_p), .call(call),
    .motorpin(mp[1]), .floor_led(fl[1]), .pending(pd[1]),
    .moving(mv[1]), .dir_up(du[1]), .door_open(dr[1])
  );

  // Floor the car is at, or last left while travelling.
  function automatic int m_floor(int k);
    return m_up[k] ? m_pos[k] / SPF : (m_pos[k] + SPF - 1) / SPF;
  endfunction

  // Coil phase follows absolute position from the reset point.
  function automatic out_t m_out(int k);
    out_t o;
    int ph;
    bit run;
    ph = (k == 0) ? (m_pos[k] % 8) : ((1 + 2 * m_pos[k]) % 8);
    run = (m_mode[k] == M_MOVE) || (m_mode[k] == M_ARR);
    o.mp = run ? ptab[ph] : 4'b0000;
    o.fl = NF'(1) << m_floor(k);
    o.pd = m_req[k];
    o.mv = run;
    o.du = m_up[k];
    o.dr = m_mode[k] == M_DOOR;
    return o;
  endfunction

  function automatic void m_reset(int k);
    m_mode[k] = M_IDLE;
    m_pos[k] = 0;
    m_el[k] = 0;
    m_left[k] = 0;
    m_up[k] = 1'b1;
    m_req[k] = '0;
  endfunction

  function automatic void m_step(int k);
    int f;
    bit [NF-1:0] ro, rn;
    bit open, restart, up_any, dn_any, ahead, behind;
    f = m_floor(k);
    ro = m_req[k];
    rn = ro;
    open = (m_mode[k] == M_IDLE) || (m_mode[k] == M_DOOR);
    restart = 1'b0;
    up_any = 1'b0;
    dn_any = 1'b0;
    for (int i = 0; i < NF; i++) begin
      if (call[i]) begin
        if (open && i == f) restart = 1'b1;
        else rn[i] = 1'b1;
      end
      if (ro[i] && i > f) up_any = 1'b1;
      if (ro[i] && i < f) dn_any = 1'b1;
    end
    ahead = m_up[k] ? up_any : dn_any;
    behind = m_up[k] ? dn_any : up_any;
    case (m_mode[k])
      M_IDLE: begin
        if (restart || ro[f]) begin
          m_mode[k] = M_DOOR;
          m_left[k] = DWL;
          rn[f] = 1'b0;
        end else if (ro != '0) begin
          if (!ahead) m_up[k] = !m_up[k];
          m_mode[k] = M_MOVE;
          m_el[k] = 0;
        end
      end
      M_MOVE: begin
        m_el[k]++;
        if (m_el[k] == SDIV) begin
          m_el[k] = 0;
          m_pos[k] += m_up[k] ? 1 : -1;
          if (m_pos[k] % SPF == 0) m_mode[k] = M_ARR;
        end
      end
      M_ARR: begin
        if (ro[f]) begin
          m_mode[k] = M_DOOR;
          m_left[k] = DWL;
          rn[f] = 1'b0;
        end else if (ahead) begin
          m_mode[k] = M_MOVE;
          m_el[k] = 0;
        end else if (behind) begin
          m_up[k] = !m_up[k];
          m_mode[k] = M_MOVE;
          m_el[k] = 0;
        end else begin
          m_mode[k] = M_IDLE;
        end
      end
      default: begin
        if (restart) m_left[k] = DWL;
        else if (m_left[k] == 1) m_mode[k] = M_IDLE;
        else m_left[k]--;
      end
    endcase
    m_req[k] = rn;
  endfunction

  function automatic out_t dut_out(int k);
    out_t o;
    o.mp = mp[k];
    o.fl = fl[k];
    o.pd = pd[k];
    o.mv = mv[k];
    o.du = du[k];
    o.dr = dr[k];
    return o;
  endfunction

  function automatic int q_size(int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic rec_t q_pop(int k);
    return (k == 0) ? q0.pop_front() : q1.pop_front();
  endfunction

  function automatic int q_head_cyc(int k);
    return (k == 0) ? int'(q0[0].cyc) : int'(q1[0].cyc);
  endfunction

  // Reference model: advances on every edge, queues expected output changes.
  always @(posedge clk) begin
    out_t o;
    rec_t r;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (reset_p) m_reset(k);
      else m_step(k);
      o = m_out(k);
      if (!reset_p && o != m_last[k]) begin
        r.cyc = 32'(cyc);
        r.o = o;
        if (k == 0) q0.push_back(r);
        else q1.push_back(r);
      end
      m_last[k] = o;
    end
    if (reset_p) begin
      q0.delete();
      q1.delete();
    end
  end

  // Monitor: any DUT output change pops and checks one expected record.
  always @(negedge clk) begin
    out_t cur;
    rec_t e;
    for (int k = 0; k < 2; k++) begin
      cur = dut_out(k);
      if (reset_p) begin
        prev[k] = cur;
      end else begin
        if (cur !== prev[k]) begin
          checks++;
          if (q_size(k) == 0) begin
            failures++;
            $display("FAIL unexpected_change inst=%0d cyc=%0d got mp=%b fl=%b pd=%b mv=%b du=%b dr=%b",
                     k, cyc, cur.mp, cur.fl, cur.pd, cur.mv, cur.du, cur.dr);
          end else begin
            e = q_pop(k);
            if (int'(e.cyc) != cyc || e.o !== cur) begin
              failures++;
              $display("FAIL output_event inst=%0d cyc=%0d got mp=%b fl=%b pd=%b mv=%b du=%b dr=%b want cyc=%0d mp=%b fl=%b pd=%b mv=%b du=%b dr=%b",
                       k, cyc, cur.mp, cur.fl, cur.pd, cur.mv, cur.du, cur.dr,
                       e.cyc, e.o.mp, e.o.fl, e.o.pd, e.o.mv, e.o.du, e.o.dr);
            end
          end
          prev[k] = cur;
        end
        while (q_size(k) != 0 && q_head_cyc(k) < cyc) begin
          e = q_pop(k);
          checks++;
          failures++;
          $display("FAIL missing_change inst=%0d cyc=%0d want_cyc=%0d want mp=%b fl=%b pd=%b mv=%b du=%b dr=%b",
                   k, cyc, e.cyc, e.o.mp, e.o.fl, e.o.pd, e.o.mv, e.o.du, e.o.dr);
        end
      end
    end
  end

  task automatic chk(input string nm, input int k,
                     input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d got=%h want=%h", nm, k, got, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk({tag, "_motorpin"}, k, 32'(mp[k]), 32'h0);
      chk({tag, "_floor_led"}, k, 32'(fl[k]), 32'h1);
      chk({tag, "_pending"}, k, 32'(pd[k]), 32'h0);
      chk({tag, "_door_open"}, k, 32'(dr[k]), 32'h0);
      chk({tag, "_moving"}, k, 32'(mv[k]), 32'h0);
      chk({tag, "_dir_up"}, k, 32'(du[k]), 32'h1);
    end
  endtask

  task automatic pulse(input logic [NF-1:0] v);
    @(posedge clk);
    #1 call = v;
    @(posedge clk);
    #1 call = '0;
  endtask

  task automatic wait_quiet(input int budget);
    int n;
    n = 0;
    while (n < budget &&
           (mv[0] || dr[0] || pd[0] != '0 || mv[1] || dr[1] || pd[1] != '0)) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL quiet_timeout got_cycles=%0d want_below=%0d", n, budget);
    end
  endtask

  task automatic random_calls(input int iters);
    logic [NF-1:0] m;
    for (int it = 0; it < iters; it++) begin
      repeat ($urandom_range(0, 40)) @(posedge clk);
      if ($urandom_range(0, 3) == 0) m = NF'($urandom_range(1, (1 << NF) - 1));
      else m = NF'(1) << $urandom_range(0, NF - 1);
      pulse(m);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 chk_reset("init");
    reset_p = 1'b0;
    repeat (5) @(posedge clk);
    #1 chk_reset("idle");

    pulse(4'b0100);
    wait_quiet(1000);
    pulse(4'b1001);
    wait_quiet(1000);
    pulse(4'b1000);
    repeat (4) @(posedge clk);
    pulse(4'b0010);
    wait_quiet(1000);
    pulse(4'b1000);
    repeat (6) @(posedge clk);
    pulse(4'b1000);
    wait_quiet(1000);
    pulse(4'b0001);
    wait_quiet(1000);

    random_calls(300);
    wait_quiet(2000);

    pulse(4'b1111);
    n = 0;
    while (!mv[0] && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("reach_move", 0, 32'(mv[0]), 32'h1);
    repeat (5) @(posedge clk);
    #3 reset_p = 1'b1;
    #1 chk_reset("async");
    @(posedge clk);
    #1 reset_p = 1'b0;
    repeat (20) @(posedge clk);
    #1 chk_reset("held");

    random_calls(100);
    wait_quiet(2000);
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++)
      chk("leftover_expected", k, 32'(q_size(k)), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
